// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, S-box table and lookup, round constants,
// and the key-expansion state encoding.
package aes_pkg;

    localparam int unsigned AES_WORD_W    = 32;
    localparam int unsigned AES_BLOCK_W   = 128;
    localparam int unsigned AES_NUM_RKEYS = 11;

    typedef logic [AES_WORD_W-1:0]  aes_word_t;
    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        XOR  = 2'd2
    } aes_ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] aes_sbox_f(input logic [7:0] i_b);
        return SBOX[i_b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte AES S-box lookup, shared by key expansion and the cipher core.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = aes_sbox_f(i_byte);

endmodule

// File: rtl/aes_key_exp.sv
// Iterative AES-128 key expansion into an 11-entry round-key file with a random-access read port.
// FAST_MODE=1 computes one round per cycle; FAST_MODE=0 shares one S-box over four byte cycles.
module aes_key_exp
    import aes_pkg::*;
#(
    parameter bit FAST_MODE = 1'b0
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AES_BLOCK_W-1:0] s_key,
    input  logic                   s_key_valid,
    output logic                   s_key_ready,
    input  logic [3:0]             m_rkey_sel,
    output logic [AES_BLOCK_W-1:0] m_rkey,
    output logic [AES_BLOCK_W-1:0] m_rkey10,
    output logic                   m_rkey_valid
);

    localparam int unsigned LAST_ROUND = 10;

    aes_ks_state_e r_state;
    logic [3:0]    r_round;
    logic [1:0]    r_byte;
    aes_word_t     r_tmp;
    aes_block_t    r_rkey [AES_NUM_RKEYS];
    logic          r_ready;
    logic          r_valid;

    aes_block_t    w_prev;
    aes_word_t     w_rot;
    aes_word_t     w_sub;
    aes_word_t     w_t;
    aes_word_t     w_w0, w_w1, w_w2, w_w3;
    aes_block_t    w_next;
    logic [7:0]    w_rcon;
    logic [7:0]    w_sb_in;
    logic [7:0]    w_sb_out;

    // Previous round key; guarded so idle-time round=0 never indexes out of range
    always_comb begin
        w_prev = r_rkey[0];
        if (r_round != 4'd0 && r_round <= 4'(LAST_ROUND)) begin
            w_prev = r_rkey[r_round - 4'd1];
        end
    end

    assign w_rot = {w_prev[23:0], w_prev[31:24]};

    always_comb begin
        w_sb_in = w_rot[31:24];
        case (r_byte)
            2'd0:    w_sb_in = w_rot[31:24];
            2'd1:    w_sb_in = w_rot[23:16];
            2'd2:    w_sb_in = w_rot[15:8];
            default: w_sb_in = w_rot[7:0];
        endcase
    end

    generate
        if (FAST_MODE) begin : g_fast
            for (genvar i = 0; i < 4; i++) begin : g_sb
                aes_sbox u_sbox (
                    .i_byte (w_rot[8*i +: 8]),
                    .o_byte (w_sub[8*i +: 8])
                );
            end
            assign w_sb_out = 8'h00;
        end else begin : g_slow
            aes_sbox u_sbox (
                .i_byte (w_sb_in),
                .o_byte (w_sb_out)
            );
            assign w_sub = r_tmp;
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        if (r_round != 4'd0 && r_round <= 4'(LAST_ROUND)) begin
            w_rcon = RCON[r_round];
        end
    end

    assign w_t    = w_sub ^ {w_rcon, 24'h000000};
    assign w_w0   = w_prev[127:96] ^ w_t;
    assign w_w1   = w_prev[95:64]  ^ w_w0;
    assign w_w2   = w_prev[63:32]  ^ w_w1;
    assign w_w3   = w_prev[31:0]   ^ w_w2;
    assign w_next = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_round <= 4'd0;
            r_byte  <= 2'd0;
            r_tmp   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            for (int i = 0; i < int'(AES_NUM_RKEYS); i++) begin
                r_rkey[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_key_valid && r_ready) begin
                        r_rkey[0] <= s_key;
                        r_round   <= 4'd1;
                        r_byte    <= 2'd0;
                        r_ready   <= 1'b0;
                        r_valid   <= 1'b0;
                        r_state   <= FAST_MODE ? XOR : SUB;
                    end
                end
                SUB: begin
                    case (r_byte)
                        2'd0:    r_tmp[31:24] <= w_sb_out;
                        2'd1:    r_tmp[23:16] <= w_sb_out;
                        2'd2:    r_tmp[15:8]  <= w_sb_out;
                        default: r_tmp[7:0]   <= w_sb_out;
                    endcase
                    r_byte <= r_byte + 2'd1;
                    if (r_byte == 2'd3) begin
                        r_state <= XOR;
                    end
                end
                XOR: begin
                    r_rkey[r_round] <= w_next;
                    if (r_round == 4'(LAST_ROUND)) begin
                        r_round <= 4'd0;
                        r_ready <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_state <= FAST_MODE ? XOR : SUB;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read port is combinational so a consumer can register sel and sample next edge
    always_comb begin
        m_rkey = '0;
        if (m_rkey_sel <= 4'(LAST_ROUND)) begin
            m_rkey = r_rkey[m_rkey_sel];
        end
    end

    assign m_rkey10     = r_rkey[10];
    assign s_key_ready  = r_ready;
    assign m_rkey_valid = r_valid;

endmodule

// File: tb/tb_aes_key_exp.sv
// Bench for aes_key_exp: fast and slow instances side by side, checked against a FIPS-197
// word-recurrence model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_exp;

    localparam logic [127:0] NIST_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] NIST_RK5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] NIST_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam int           TIMEOUT   = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_f, key_s;
    logic         kv_f, kv_s;
    logic         rdy_f, rdy_s;
    logic [3:0]   sel_f, sel_s;
    logic [127:0] rk_f, rk_s, rk10_f, rk10_s;
    logic         vld_f, vld_s;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]   ref_sbox  [256];
    logic [127:0] exp_sched [11];
    logic [127:0] got_sched [11];

    always #5 clk = ~clk;

    aes_key_exp #(.FAST_MODE(1'b1)) u_fast (
        .clk(clk), .rst_n(rst_n),
        .s_key(key_f), .s_key_valid(kv_f), .s_key_ready(rdy_f),
        .m_rkey_sel(sel_f), .m_rkey(rk_f), .m_rkey10(rk10_f), .m_rkey_valid(vld_f)
    );

    aes_key_exp #(.FAST_MODE(1'b0)) u_slow (
        .clk(clk), .rst_n(rst_n),
        .s_key(key_s), .s_key_valid(kv_s), .s_key_ready(rdy_s),
        .m_rkey_sel(sel_s), .m_rkey(rk_s), .m_rkey10(rk10_s), .m_rkey_valid(vld_s)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                for (int c = 1; c < 256; c++) begin
                    if (gf_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
                end
            end
            ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {ref_sbox[temp[31:24]], ref_sbox[temp[23:16]], ref_sbox[temp[15:8]], ref_sbox[temp[7:0]]};
                temp = temp ^ {rc, 24'h000000};
                rc   = rc[7] ? (8'(rc << 1) ^ 8'h1b) : 8'(rc << 1);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) begin
            exp_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // ---------------- DUT access ----------------
    function automatic logic get_ready(input bit fast);
        return fast ? rdy_f : rdy_s;
    endfunction

    function automatic logic get_valid(input bit fast);
        return fast ? vld_f : vld_s;
    endfunction

    function automatic logic [127:0] get_rkey(input bit fast);
        return fast ? rk_f : rk_s;
    endfunction

    function automatic logic [127:0] get_rk10(input bit fast);
        return fast ? rk10_f : rk10_s;
    endfunction

    task automatic set_in(input bit fast, input logic [127:0] k, input logic v);
        if (fast) begin key_f = k; kv_f = v; end
        else      begin key_s = k; kv_s = v; end
    endtask

    task automatic set_sel(input bit fast, input logic [3:0] s);
        if (fast) sel_f = s;
        else      sel_s = s;
    endtask

    // Call just after a negedge; returns just after the negedge following the accept edge
    task automatic offer_key(input bit fast, input logic [127:0] k);
        int n;
        n = 0;
        while (!get_ready(fast) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (!get_ready(fast)) begin
            vectors++;
            miscompares++;
            $display("FAIL offer_ready mode=%0d: ready stayed %b, required 1", fast, get_ready(fast));
        end
        set_in(fast, k, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in(fast, k, 1'b0);
    endtask

    task automatic wait_valid(input bit fast, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!get_valid(fast) && cycles < TIMEOUT);
    endtask

    task automatic read_sched(input bit fast);
        for (int r = 0; r < 11; r++) begin
            @(negedge clk);
            set_sel(fast, 4'(r));
            #1;
            got_sched[r] = get_rkey(fast);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int f = 0; f < 2; f++) begin
            bit fb;
            fb = f[0];
            vectors += 5;
            if (get_ready(fb) !== 1'b1) begin miscompares++; $display("FAIL reset_ready mode=%0d got %b exp 1", fb, get_ready(fb)); end
            if (get_valid(fb) !== 1'b0) begin miscompares++; $display("FAIL reset_valid mode=%0d got %b exp 0", fb, get_valid(fb)); end
            if (get_rk10(fb) !== 128'h0) begin miscompares++; $display("FAIL reset_rk10 mode=%0d got %h exp 0", fb, get_rk10(fb)); end
            read_sched(fb);
            if (got_sched[0] !== 128'h0) begin miscompares++; $display("FAIL reset_rkey0 mode=%0d got %h exp 0", fb, got_sched[0]); end
            if (got_sched[10] !== 128'h0) begin miscompares++; $display("FAIL reset_rkey10 mode=%0d got %h exp 0", fb, got_sched[10]); end
        end
    endtask

    task automatic test_nist(input bit fast);
        int lat;
        model_expand(NIST_KEY);
        @(negedge clk);
        offer_key(fast, NIST_KEY);
        vectors += 2;
        if (get_valid(fast) !== 1'b0) begin miscompares++; $display("FAIL nist_valid_drop mode=%0d got %b exp 0", fast, get_valid(fast)); end
        if (get_ready(fast) !== 1'b0) begin miscompares++; $display("FAIL nist_busy mode=%0d got %b exp 0", fast, get_ready(fast)); end
        wait_valid(fast, lat);
        vectors++;
        if (lat !== (fast ? 10 : 50)) begin miscompares++; $display("FAIL nist_latency mode=%0d got %0d exp %0d", fast, lat, fast ? 10 : 50); end
        read_sched(fast);
        for (int r = 0; r < 11; r++) begin
            vectors++;
            if (got_sched[r] !== exp_sched[r]) begin miscompares++; $display("FAIL nist_rkey%0d mode=%0d got %h exp %h", r, fast, got_sched[r], exp_sched[r]); end
        end
        vectors += 3;
        if (got_sched[1] !== NIST_RK1) begin miscompares++; $display("FAIL nist_rk1_const mode=%0d got %h exp %h", fast, got_sched[1], NIST_RK1); end
        if (got_sched[5] !== NIST_RK5) begin miscompares++; $display("FAIL nist_rk5_const mode=%0d got %h exp %h", fast, got_sched[5], NIST_RK5); end
        if (get_rk10(fast) !== NIST_RK10) begin miscompares++; $display("FAIL nist_rk10_port mode=%0d got %h exp %h", fast, get_rk10(fast), NIST_RK10); end
        for (int s = 11; s < 16; s += 4) begin
            @(negedge clk);
            set_sel(fast, 4'(s));
            #1;
            vectors++;
            if (get_rkey(fast) !== 128'h0) begin miscompares++; $display("FAIL sel_oob%0d mode=%0d got %h exp 0", s, fast, get_rkey(fast)); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        model_expand(NIST_KEY);
        @(negedge clk);
        offer_key(1'b1, NIST_KEY);
        @(negedge clk);
        @(negedge clk);
        set_in(1'b1, 128'h0, 1'b1);
        vectors++;
        if (rdy_f !== 1'b0) begin miscompares++; $display("FAIL busy_ready got %b exp 0", rdy_f); end
        @(negedge clk);
        set_in(1'b1, 128'h0, 1'b0);
        wait_valid(1'b1, lat);
        vectors += 2;
        if (lat !== 7) begin miscompares++; $display("FAIL busy_latency got %0d exp 7", lat); end
        if (rk10_f !== NIST_RK10) begin miscompares++; $display("FAIL busy_rk10 got %h exp %h", rk10_f, NIST_RK10); end
        read_sched(1'b1);
        for (int r = 0; r < 11; r++) begin
            vectors++;
            if (got_sched[r] !== exp_sched[r]) begin miscompares++; $display("FAIL busy_rkey%0d got %h exp %h", r, got_sched[r], exp_sched[r]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] k;
        @(negedge clk);
        offer_key(1'b0, NIST_KEY);
        repeat (24) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (vld_s !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b exp 0", vld_s); end
        if (rdy_s !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b exp 1", rdy_s); end
        if (rk10_s !== 128'h0) begin miscompares++; $display("FAIL midrst_rk10 got %h exp 0", rk10_s); end
        for (int s = 0; s < 16; s++) begin
            set_sel(1'b0, 4'(s));
            #1;
            vectors++;
            if (rk_s !== 128'h0) begin miscompares++; $display("FAIL midrst_rkey%0d got %h exp 0", s, rk_s); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(k);
        @(negedge clk);
        offer_key(1'b0, k);
        wait_valid(1'b0, lat);
        vectors++;
        if (lat !== 50) begin miscompares++; $display("FAIL midrst_latency got %0d exp 50", lat); end
        read_sched(1'b0);
        for (int r = 0; r < 11; r++) begin
            vectors++;
            if (got_sched[r] !== exp_sched[r]) begin miscompares++; $display("FAIL midrst_rkey%0d got %h exp %h", r, got_sched[r], exp_sched[r]); end
        end
    endtask

    task automatic test_back_to_back(input bit fast);
        int lat;
        @(negedge clk);
        offer_key(fast, NIST_KEY);
        wait_valid(fast, lat);
        vectors++;
        if (get_ready(fast) !== 1'b1) begin miscompares++; $display("FAIL b2b_ready mode=%0d got %b exp 1", fast, get_ready(fast)); end
        model_expand(SEQ_KEY);
        offer_key(fast, SEQ_KEY);
        vectors++;
        if (get_valid(fast) !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_drop mode=%0d got %b exp 0", fast, get_valid(fast)); end
        wait_valid(fast, lat);
        vectors += 2;
        if (lat !== (fast ? 10 : 50)) begin miscompares++; $display("FAIL b2b_latency mode=%0d got %0d exp %0d", fast, lat, fast ? 10 : 50); end
        if (get_rk10(fast) !== SEQ_RK10) begin miscompares++; $display("FAIL b2b_rk10 mode=%0d got %h exp %h", fast, get_rk10(fast), SEQ_RK10); end
        read_sched(fast);
        for (int r = 0; r < 11; r++) begin
            vectors++;
            if (got_sched[r] !== exp_sched[r]) begin miscompares++; $display("FAIL b2b_rkey%0d mode=%0d got %h exp %h", r, fast, got_sched[r], exp_sched[r]); end
        end
    endtask

    task automatic test_random(input bit fast, input int n);
        int lat;
        logic [127:0] k;
        for (int i = 0; i < n; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(k);
            @(negedge clk);
            offer_key(fast, k);
            wait_valid(fast, lat);
            vectors += 2;
            if (lat !== (fast ? 10 : 50)) begin miscompares++; $display("FAIL rand_latency mode=%0d key=%h got %0d", fast, k, lat); end
            if (get_rk10(fast) !== exp_sched[10]) begin miscompares++; $display("FAIL rand_rk10 mode=%0d got %h exp %h", fast, get_rk10(fast), exp_sched[10]); end
            read_sched(fast);
            for (int r = 0; r < 11; r++) begin
                vectors++;
                if (got_sched[r] !== exp_sched[r]) begin miscompares++; $display("FAIL rand_rkey%0d mode=%0d got %h exp %h", r, fast, got_sched[r], exp_sched[r]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_f = '0; key_s = '0;
        kv_f  = 1'b0; kv_s = 1'b0;
        sel_f = 4'd0; sel_s = 4'd0;
        build_sbox();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_nist(1'b1);
        test_nist(1'b0);
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back(1'b1);
        test_back_to_back(1'b0);
        test_random(1'b1, 4);
        test_random(1'b0, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_key_exp.md
# aes_key_exp

Iterative AES-128 key expansion stage that sits directly upstream of `aes_enc`. It accepts one 128-bit cipher key and computes the 11 round keys (rkey[0..10]) into an internal register file. It then exposes them through a random-access read port and a schedule-valid flag. `aes_enc` reads its per-round key from this block instead of using bench-supplied constants.

## Interface
- FAST_MODE, 0, 0: one S-box and 5 cycles per round; 1: four S-boxes and 1 cycle per round.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_key  in  128  cipher key; bits [127:96] = w0, [31:0] = w3.
- s_key_valid  in  1  key offer.
- s_key_ready  out  1  high when idle; a key is accepted on an edge where valid && ready.
- m_rkey_sel  in  4  round key index, 0..10.
- m_rkey  out  128  rkey[m_rkey_sel], combinational read; 0 for sel 11..15.
- m_rkey10  out  128  rkey[10], always driven, used as the decipher start key.
- m_rkey_valid  out  1  high when the complete schedule for the last accepted key is stored.

## Operation
- Reset values:
  - state IDLE, round counter 0, byte counter 0.
  - all rkey entries 0, so m_rkey = 0 and m_rkey10 = 0.
  - s_key_ready = 1, m_rkey_valid = 0.
- States:
  - IDLE: on accept, rkey[0] <= s_key and round <= 1. Go to SUB if FAST_MODE = 0, or to XOR if FAST_MODE = 1.
  - SUB (FAST_MODE = 0 only): byte counter b = 0..3. Each cycle, tmp byte b <= sbox(RotWord(rkey[round-1].w3) byte b). After b = 3, go to XOR.
  - XOR: writes rkey[round] (equations below).
    - If round = 10: go to IDLE, set m_rkey_valid = 1 and s_key_ready = 1.
    - Otherwise round++, then go to SUB (FAST_MODE = 0) or stay in XOR (FAST_MODE = 1).
- Round key equations:
  - t = SubWord(RotWord(w3_prev)) ^ {Rcon[round], 24'h0}.
  - w0 = w0_prev ^ t; w1 = w1_prev ^ w0; w2 = w2_prev ^ w1; w3 = w3_prev ^ w2. All arithmetic is XOR over GF(2^8).
- RotWord({a,b,c,d}) = {b,c,d,a}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- In FAST_MODE = 1, SubWord is four parallel S-box lookups in the XOR cycle.
- On accept, m_rkey_valid drops to 0 on the same edge. Old entries rkey[1..10] stay readable but stale until they are overwritten.
- s_key_valid while busy is ignored. There is no queueing, and the in-progress expansion is unaffected.
- Reset asserted mid-expansion aborts immediately and returns all outputs to their reset values. A partial schedule is never flagged valid.

## Timing
- Key accepted on edge k.
- FAST_MODE = 1:
  - rkey[r] is written on edge k+r.
  - m_rkey_valid and s_key_ready are high after edge k+10, giving latency 10 cycles.
- FAST_MODE = 0:
  - rkey[r] is written on edge k+5r.
  - valid and ready are high after edge k+50, giving latency 50 cycles.
- Back-to-back keys: the next key can be accepted on the first edge on which s_key_ready = 1, i.e. edge k+11 (fast) or k+51 (slow).
- m_rkey follows m_rkey_sel combinationally with no added latency. `aes_enc` can register sel and sample m_rkey on the following edge.

## Structure
- Shared package `aes_pkg` holds:
  - the S-box as a 256-entry constant array and an `aes_sbox_f` function;
  - the RCON[1:10] constant;
  - the state enum {IDLE, SUB, XOR};
  - the word and block typedefs (aes_word_t 32-bit, aes_block_t 128-bit).
- Sub-module `aes_sbox`: a combinational one-byte lookup wrapping `aes_sbox_f`. It is instantiated once (FAST_MODE = 0) or four times (FAST_MODE = 1) via generate. `aes_enc` reuses the same sub-module.

## Test plan
- NIST key 2b7e151628aed2a6abf7158809cf4f3c, both modes:
  - rkey[1] = a0fafe1788542cb123a339392a6c7605 and rkey[5] = d4d1c6f87c839d87caf2b8bc11f915bc;
  - m_rkey10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - valid rises exactly 10 cycles (fast) or 50 cycles (slow) after accept.
- During fast-mode expansion, drive s_key_valid with key 0 at cycle k+3 -> no effect; the NIST schedule completes unchanged.
- Assert rst_n = 0 at cycle k+25 in slow mode -> valid = 0, ready = 1, and m_rkey = 0 for all sel; a fresh accept afterwards then produces the correct schedule.
- Back-to-back keys: NIST key, then key 000102030405060708090a0b0c0d0e0f at the first ready edge -> rkey[10] = 13111d7fe3944a17f307a78b4d2b30c5.
- m_rkey_sel = 11 and 15 -> m_rkey = 0. Sweep sel = 0..10 -> every stored value matches the NIST table.
- Integration with `aes_enc` (both FAST_MODE values) on the NIST key: plaintext 6bc1bee22e409f96e93d7e117393172a -> ciphertext 3ad77bb40d7a3660a89ecaf32466ef97.
